// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the EEPROM boot loader: the EEPROM byte-address width
// and the 3-bit state encoding of the copy sequencer.
// No ports (package).
// ---------------------------------------------------------------------------
package boot_pkg;

  localparam int EEPROM_ADDR_WIDTH = 11;

  typedef enum logic [2:0] {
    S_REQUEST   = 3'd0,
    S_WAIT_ACK  = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WRITE     = 3'd3,
    S_NEXT      = 3'd4,
    S_CHECK     = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } boot_state_e;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single-bit level crossing into the clk_i domain.
// Both flops reset to 0, so a synchronised "ready" reads as not-ready until
// two clocks after reset is released.
// Ports:
//   clk_i    destination clock
//   rst_n_i  asynchronous active-low reset
//   d_i      asynchronous input level
//   q_o      synchronised level
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/eeprom_boot_loader.sv
// ---------------------------------------------------------------------------
// eeprom_boot_loader
// Boot sequencer in front of the AT93C86A reader. After reset, or on a reload
// pulse in DONE/ERROR, it copies IMAGE_BYTES bytes from EEPROM into code RAM,
// one reader transaction per byte, then releases the CPU from reset.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, one extra byte is read from EEPROM_BASE+IMAGE_BYTES (never
//   written to RAM); the 8-bit sum of the image plus that byte must be 8'h00,
//   otherwise the loader ends in ERROR with the CPU held in reset.
//
// Ports:
//   clk_i               system clock (same source as the reader's raw clock)
//   reset_n_i           asynchronous active-low reset
//   reload_i            one-cycle restart pulse, honoured only in DONE/ERROR
//   eeprom_address_o    byte address presented to the reader
//   eeprom_strobe_o     read request, held until the reader drops ready
//   eeprom_ready_i      reader ready (foreign clock domain, synchronised here)
//   eeprom_data_i       reader data_out
//   mem_address_o       RAM write address
//   mem_write_data_o    RAM write data
//   mem_write_enable_o  one-cycle RAM write strobe
//   cpu_reset_n_o       0 holds the CPU in reset; 1 only in DONE
//   busy_o              copy in progress
//   done_o              image loaded (and verified when checksum is enabled)
//   error_o             handshake timeout or checksum mismatch (sticky)
// ---------------------------------------------------------------------------
module eeprom_boot_loader
  import boot_pkg::*;
#(
  parameter int IMAGE_BYTES    = 1024,
  parameter int EEPROM_BASE    = 0,
  parameter int RAM_BASE       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         reload_i,
  output logic [EEPROM_ADDR_WIDTH-1:0] eeprom_address_o,
  output logic                         eeprom_strobe_o,
  input  logic                         eeprom_ready_i,
  input  logic [7:0]                   eeprom_data_i,
  output logic [EEPROM_ADDR_WIDTH-1:0] mem_address_o,
  output logic [7:0]                   mem_write_data_o,
  output logic                         mem_write_enable_o,
  output logic                         cpu_reset_n_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam logic [EEPROM_ADDR_WIDTH-1:0] EEPROM_BASE_A = EEPROM_ADDR_WIDTH'(EEPROM_BASE);
  localparam logic [EEPROM_ADDR_WIDTH-1:0] RAM_BASE_A    = EEPROM_ADDR_WIDTH'(RAM_BASE);
  localparam logic [11:0]                  LAST_INDEX    = 12'(IMAGE_BYTES - 1);
  localparam logic [10:0]                  TIMEOUT_LAST  = 11'(TIMEOUT_CYCLES - 1);

  boot_state_e state_q, state_d;
  // 12 bits so the checksum byte index (IMAGE_BYTES, up to 2048) fits.
  logic [11:0] index_q, index_d;
  logic [10:0] wait_q, wait_d;
  logic [7:0]  data_q, data_d;
  logic [EEPROM_ADDR_WIDTH-1:0] eeprom_address_q, eeprom_address_d;
  logic        strobe_q, strobe_d;
  logic [EEPROM_ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_reset_n_q, cpu_reset_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        counting;
  logic        rdy_s;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        sum_phase_q, sum_phase_d;
`endif

  sync_2ff u_ready_sync (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .d_i     (eeprom_ready_i),
    .q_o     (rdy_s)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= S_REQUEST;
      index_q          <= '0;
      wait_q           <= '0;
      data_q           <= '0;
      eeprom_address_q <= EEPROM_BASE_A;
      strobe_q         <= 1'b0;
      mem_address_q    <= '0;
      mem_data_q       <= '0;
      mem_we_q         <= 1'b0;
      cpu_reset_n_q    <= 1'b0;
      busy_q           <= 1'b1;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q            <= '0;
      sum_phase_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      index_q          <= index_d;
      wait_q           <= wait_d;
      data_q           <= data_d;
      eeprom_address_q <= eeprom_address_d;
      strobe_q         <= strobe_d;
      mem_address_q    <= mem_address_d;
      mem_data_q       <= mem_data_d;
      mem_we_q         <= mem_we_d;
      cpu_reset_n_q    <= cpu_reset_n_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q            <= sum_d;
      sum_phase_q      <= sum_phase_d;
`endif
    end
  end

  // All outputs are registered; entry side effects of DONE/ERROR are applied
  // after the case so that a timeout and a normal transition share them.
  always_comb begin
    state_d          = state_q;
    index_d          = index_q;
    data_d           = data_q;
    eeprom_address_d = eeprom_address_q;
    strobe_d         = strobe_q;
    mem_address_d    = mem_address_q;
    mem_data_d       = mem_data_q;
    mem_we_d         = 1'b0;
    cpu_reset_n_d    = cpu_reset_n_q;
    busy_d           = busy_q;
    done_d           = done_q;
    error_d          = error_q;
    counting         = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d            = sum_q;
    sum_phase_d      = sum_phase_q;
`endif

    case (state_q)
      S_REQUEST: begin
        counting = 1'b1;
        if (rdy_s) begin
          eeprom_address_d = EEPROM_BASE_A + index_q[EEPROM_ADDR_WIDTH-1:0];
          strobe_d         = 1'b1;
          state_d          = S_WAIT_ACK;
        end
      end
      // The reader only samples strobe on its divided clock, so strobe stays
      // high until the synchronised ready is seen low.
      S_WAIT_ACK: begin
        counting = 1'b1;
        if (!rdy_s) begin
          strobe_d = 1'b0;
          state_d  = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        counting = 1'b1;
        if (rdy_s) begin
          data_d  = eeprom_data_i;
`ifdef BOOT_CHECKSUM_EN
          state_d = sum_phase_q ? S_CHECK : S_WRITE;
`else
          state_d = S_WRITE;
`endif
        end
      end
      S_WRITE: begin
        mem_address_d = RAM_BASE_A + index_q[EEPROM_ADDR_WIDTH-1:0];
        mem_data_d    = data_q;
        mem_we_d      = 1'b1;
`ifdef BOOT_CHECKSUM_EN
        sum_d         = sum_q + data_q;
`endif
        state_d       = S_NEXT;
      end
      S_NEXT: begin
        if (index_q == LAST_INDEX) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          index_d = index_q + 12'd1;
          state_d = S_REQUEST;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      // First visit launches the extra checksum read; the second visit (after
      // that read returns) judges the running sum.
      S_CHECK: begin
        if (!sum_phase_q) begin
          sum_phase_d = 1'b1;
          index_d     = 12'(IMAGE_BYTES);
          state_d     = S_REQUEST;
        end else if (8'(sum_q + data_q) == 8'h00) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERROR;
        end
      end
`endif
      S_DONE, S_ERROR: begin
        if (reload_i) begin
          done_d        = 1'b0;
          error_d       = 1'b0;
          cpu_reset_n_d = 1'b0;
          busy_d        = 1'b1;
          index_d       = '0;
          state_d       = S_REQUEST;
`ifdef BOOT_CHECKSUM_EN
          sum_d         = '0;
          sum_phase_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_ERROR;
    endcase

    // Handshake watchdog: only fires when the state would otherwise stay put.
    if (counting && (state_d == state_q) && (wait_q == TIMEOUT_LAST)) begin
      state_d = S_ERROR;
    end

    if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
      busy_d        = 1'b0;
      error_d       = 1'b1;
      done_d        = 1'b0;
      cpu_reset_n_d = 1'b0;
      strobe_d      = 1'b0;
    end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      busy_d        = 1'b0;
      done_d        = 1'b1;
      cpu_reset_n_d = 1'b1;
    end

    if ((state_d != state_q) || !counting) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + 11'd1;
    end
  end

  assign eeprom_address_o   = eeprom_address_q;
  assign eeprom_strobe_o    = strobe_q;
  assign mem_address_o      = mem_address_q;
  assign mem_write_data_o   = mem_data_q;
  assign mem_write_enable_o = mem_we_q;
  assign cpu_reset_n_o      = cpu_reset_n_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign error_o            = error_q;

endmodule

// File: tb/tb_eeprom_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_eeprom_boot_loader
// Directed bench for eeprom_boot_loader. A small reader model answers strobes
// on a divided clock (every 4th clk) and a RAM model logs every write.
// The image lives at EEPROM 2046,2047,0,1 so the address wrap is exercised on
// every copy. Optional checksum steps are compiled with BOOT_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_eeprom_boot_loader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        reload = 1'b0;
  logic [10:0] eepAddr;
  logic        eepStrobe;
  logic        rdrReady = 1'b1;
  logic [7:0]  rdrData = 8'h00;
  logic [10:0] memAddr;
  logic [7:0]  memWdata;
  logic        memWe;
  logic        cpuResetN;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  eeprom [2048];
  logic        stuck = 1'b0;
  logic [1:0]  divCnt = 2'd0;
  int          busyTicks = 0;
  logic [10:0] rdAddr = '0;
  int          readLog [$];
  int          writeLog [$];

  eeprom_boot_loader #(
    .IMAGE_BYTES    (4),
    .EEPROM_BASE    (2046),
    .RAM_BASE       (0),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (resetN),
    .reload_i           (reload),
    .eeprom_address_o   (eepAddr),
    .eeprom_strobe_o    (eepStrobe),
    .eeprom_ready_i     (rdrReady),
    .eeprom_data_i      (rdrData),
    .mem_address_o      (memAddr),
    .mem_write_data_o   (memWdata),
    .mem_write_enable_o (memWe),
    .cpu_reset_n_o      (cpuResetN),
    .busy_o             (busy),
    .done_o             (done),
    .error_o            (error)
  );

  always #5 clk = ~clk;

  // Reader model: looks at strobe once every 4 clks, drops ready for 3 of its
  // ticks, then presents the addressed byte with ready high again.
  always @(posedge clk) begin
    divCnt <= divCnt + 2'd1;
    if (divCnt == 2'd3) begin
      if (rdrReady) begin
        if (eepStrobe && !stuck) begin
          rdAddr    <= eepAddr;
          readLog.push_back(int'(eepAddr));
          rdrReady  <= 1'b0;
          busyTicks <= 3;
        end
      end else if (busyTicks == 1) begin
        rdrData  <= eeprom[rdAddr];
        rdrReady <= 1'b1;
      end else begin
        busyTicks <= busyTicks - 1;
      end
    end
  end

  // RAM model: one log entry per clock with the write strobe high.
  always @(posedge clk) begin
    if (memWe) writeLog.push_back((int'(memAddr) << 8) | int'(memWdata));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic resetLevel, input logic reloadLevel);
    @(negedge clk);
    resetN = resetLevel;
    reload = reloadLevel;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_eep_addr"}, 32'(eepAddr), 32'd2046);
    checkOutput({tag, "_strobe"}, 32'(eepStrobe), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_mem_data"}, 32'(memWdata), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(memWe), 32'd0);
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpuResetN), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic checkImage(input string tag, input int startW);
    int img [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    checkOutput({tag, "_write_count"}, 32'(writeLog.size() - startW), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (startW + i < writeLog.size())
        checkOutput($sformatf("%s_ram%0d", tag, i), 32'(writeLog[startW + i]), 32'((i << 8) | img[i]));
    end
  endtask

  initial begin
    int startW;
    int startR;
    int n;
    int expAddr [4] = '{2046, 2047, 0, 1};

    for (int i = 0; i < 2048; i++) eeprom[i] = 8'h00;
    eeprom[2046] = 8'h11;
    eeprom[2047] = 8'h22;
    eeprom[0]    = 8'h33;
    eeprom[1]    = 8'h44;
`ifdef BOOT_CHECKSUM_EN
    eeprom[2]    = 8'h56;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    checkResetValues("reset");

    // First copy straight out of reset, with address wrap 2047 -> 0
    startW = 0;
    startR = 0;
    resetN = 1'b1;
    waitIdle(2000);
    checkOutput("copy1_done", 32'(done), 32'd1);
    checkOutput("copy1_error", 32'(error), 32'd0);
    checkOutput("copy1_cpu_rst_n", 32'(cpuResetN), 32'd1);
    checkOutput("copy1_busy", 32'(busy), 32'd0);
    checkImage("copy1", startW);
    for (int i = 0; i < 4; i++) begin
      if (startR + i < readLog.size())
        checkOutput($sformatf("copy1_rd%0d", i), 32'(readLog[startR + i]), 32'(expAddr[i]));
      else
        checkOutput($sformatf("copy1_rd%0d_missing", i), 32'd0, 32'd1);
    end

    // Reload from DONE, then a reload mid-copy that must be ignored
    startW = writeLog.size();
    applyStimulus(1'b1, 1'b1);
    checkOutput("reload_cpu_rst_n", 32'(cpuResetN), 32'd0);
    checkOutput("reload_busy", 32'(busy), 32'd1);
    checkOutput("reload_done", 32'(done), 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("midcopy_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1);
    waitIdle(2000);
    checkOutput("copy2_done", 32'(done), 32'd1);
    checkImage("copy2", startW);

    // Reset after the second byte of a fresh copy
    applyStimulus(1'b1, 1'b1);
    startW = writeLog.size();
    n = 0;
    while (writeLog.size() < startW + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midreset_two_writes", 32'(writeLog.size() - startW), 32'd2);
    resetN = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    startW = writeLog.size();
    startR = readLog.size();
    resetN = 1'b1;
    waitIdle(2000);
    checkOutput("copy3_done", 32'(done), 32'd1);
    checkImage("copy3", startW);
    if (startR < readLog.size())
      checkOutput("copy3_first_rd", 32'(readLog[startR]), 32'd2046);
    else
      checkOutput("copy3_first_rd_missing", 32'd0, 32'd1);

    // Reader never acknowledges: timeout 64 clks after entering WAIT_ACK
    stuck = 1'b1;
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (!eepStrobe && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!error && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_latency", 32'(n), 32'd64);
    checkOutput("timeout_error", 32'(error), 32'd1);
    checkOutput("timeout_strobe", 32'(eepStrobe), 32'd0);
    checkOutput("timeout_cpu_rst_n", 32'(cpuResetN), 32'd0);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("timeout_sticky", 32'(error), 32'd1);

    // Recover from ERROR with a reload
    stuck = 1'b0;
    startW = writeLog.size();
    applyStimulus(1'b1, 1'b1);
    checkOutput("recover_error_clr", 32'(error), 32'd0);
    waitIdle(2000);
    checkOutput("recover_done", 32'(done), 32'd1);
    checkOutput("recover_error", 32'(error), 32'd0);
    checkImage("recover", startW);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum byte: image still written, loader ends in ERROR
    eeprom[2] = 8'h57;
    startW = writeLog.size();
    applyStimulus(1'b1, 1'b1);
    waitIdle(2000);
    checkOutput("badsum_error", 32'(error), 32'd1);
    checkOutput("badsum_done", 32'(done), 32'd0);
    checkOutput("badsum_cpu_rst_n", 32'(cpuResetN), 32'd0);
    checkImage("badsum", startW);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
